// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory: access types, error codes,
// FSM states and the byte-enable helper used by the store path.
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } req_type_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_TYPE     = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } state_e;

    // Little-endian lane selection; illegal types enable nothing.
    function automatic logic [3:0] byte_en(input req_type_e t, input logic [1:0] a);
        case (t)
            BYTE:    return 4'b0001 << a;
            HALF:    return a[1] ? 4'b1100 : 4'b0011;
            WORD:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram_bank.sv
// DEPTH_WORDS x 32 data storage: byte-enable synchronous write, asynchronous read.
// Contents are deliberately not reset.
module dmem_ram_bank #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_hs.sv
// Handshaked load/store data memory with wait states, lane steering, optional
// sign extension and error reporting for misaligned/out-of-window/illegal accesses.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wen,
    input  logic [1:0]  i_req_type,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic        i_req_sext,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic [1:0]  o_rsp_err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_wen;
    req_type_e   r_type;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_sext;
    err_e        r_err_pend;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    err_e        r_rsp_err;

    err_e        w_err;
    logic [31:0] w_off_in;
    logic [AW-1:0] w_idx;
    logic [3:0]  w_be;
    logic        w_we;
    logic [31:0] w_wdata;
    logic [31:0] w_rword;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // An address below the window wraps to a huge offset, so one compare covers both bounds.
    assign w_off_in = i_req_addr - BASE_ADDR;

    always_comb begin
        w_err = ERR_OK;
        if (i_req_type == ILLEGAL)
            w_err = ERR_TYPE;
        else if ((i_req_type == HALF && i_req_addr[0]) ||
                 (i_req_type == WORD && i_req_addr[1:0] != 2'b00))
            w_err = ERR_MISALIGN;
        else if (w_off_in >= WIN_BYTES)
            w_err = ERR_RANGE;
    end

    assign w_idx = AW'((r_addr - BASE_ADDR) >> 2);
    assign w_be  = byte_en(r_type, r_addr[1:0]);
    assign w_we  = (r_state == ACCESS) && r_wen;

    always_comb begin
        case (r_type)
            BYTE:    w_wdata = {4{r_wdata[7:0]}};
            HALF:    w_wdata = {2{r_wdata[15:0]}};
            default: w_wdata = r_wdata;
        endcase
    end

    dmem_ram_bank #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_idx),
        .i_wdata (w_wdata),
        .o_rdata (w_rword)
    );

    always_comb begin
        w_byte = w_rword[8*r_addr[1:0] +: 8];
        w_half = r_addr[1] ? w_rword[31:16] : w_rword[15:0];
        case (r_type)
            BYTE:    w_load = {{24{r_sext & w_byte[7]}}, w_byte};
            HALF:    w_load = {{16{r_sext & w_half[15]}}, w_half};
            default: w_load = w_rword;
        endcase
    end

    // The cycle after acceptance is always spent in WAIT: errored requests leave
    // from it straight to RESP, good ones stay WAIT_CYCLES+1 cycles, so a response
    // appears WAIT_CYCLES+2 edges after acceptance and an error one edge after.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_wen       <= 1'b0;
            r_type      <= BYTE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_sext      <= 1'b0;
            r_err_pend  <= ERR_OK;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= ERR_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_wen       <= i_req_wen;
                        r_type      <= req_type_e'(i_req_type);
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_sext      <= i_req_sext;
                        r_err_pend  <= w_err;
                        r_cnt       <= 4'd0;
                        r_req_ready <= 1'b0;
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_err_pend != ERR_OK) begin
                        r_rsp_err   <= r_err_pend;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (r_cnt == WAIT_LAST) begin
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ACCESS: begin
                    r_rsp_rdata <= r_wen ? 32'd0 : w_load;
                    r_rsp_err   <= ERR_OK;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= ERR_OK;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench: instance A (WAIT_CYCLES=1) covers data paths, errors and
// backpressure; instance B (WAIT_CYCLES=4) covers reset during a pending store.
module tb_data_memory_hs;

    localparam logic [31:0] B = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        a_rst_n, b_rst_n;
    logic        a_req_valid, b_req_valid;
    logic        req_wen;
    logic [1:0]  req_type;
    logic [31:0] req_addr, req_wdata;
    logic        req_sext, rsp_ready;
    logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
    logic [31:0] a_rsp_rdata, b_rsp_rdata;
    logic [1:0]  a_rsp_err, b_rsp_err;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    data_memory_hs #(.BASE_ADDR(B), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_wen(req_wen), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_sext(req_sext), .o_rsp_valid(a_rsp_valid),
        .i_rsp_ready(rsp_ready), .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
    );

    data_memory_hs #(.BASE_ADDR(B), .DEPTH_WORDS(1024), .WAIT_CYCLES(4)) u_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_wen(req_wen), .i_req_type(req_type), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_sext(req_sext), .o_rsp_valid(b_rsp_valid),
        .i_rsp_ready(rsp_ready), .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction with rsp_ready high; lat counts edges from acceptance to rsp_valid.
    task automatic xact(input bit sel_b, input logic wen, input logic [1:0] typ,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic sext,
                        input int exp_lat, input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input string tag);
        int lat;
        @(negedge clk);
        req_wen = wen; req_type = typ; req_addr = addr; req_wdata = wdata; req_sext = sext;
        rsp_ready = 1'b1;
        if (sel_b) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        // Scramble the request fields to prove they were latched.
        req_wen = ~wen; req_type = ~typ; req_addr = addr ^ 32'h5555_5555;
        req_wdata = ~wdata; req_sext = ~sext;
        check({tag, ".busy"}, 32'(sel_b ? b_req_ready : a_req_ready), 32'd0);
        lat = 0;
        while (!(sel_b ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},   32'(lat), 32'(exp_lat));
        check({tag, ".rdata"}, sel_b ? b_rsp_rdata : a_rsp_rdata, exp_rd);
        check({tag, ".err"},   32'(sel_b ? b_rsp_err : a_rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        check({tag, ".idle"},  32'(sel_b ? {b_req_ready, b_rsp_valid} : {a_req_ready, a_rsp_valid}), 32'd2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req_valid = 1'b0; b_req_valid = 1'b0;
        req_wen = 1'b0; req_type = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
        req_sext = 1'b0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst.ready", 32'(a_req_ready), 32'd1);
        check("rst.valid", 32'(a_rsp_valid), 32'd0);
        check("rst.rdata", a_rsp_rdata, 32'd0);
        check("rst.err",   32'(a_rsp_err), 32'd0);
        @(negedge clk); a_rst_n = 1'b1; b_rst_n = 1'b1;

        // Data paths on A (WAIT_CYCLES=1 -> 3 edges to response)
        xact(0, 1, 2'd2, B,     32'hDEAD_BEEF, 0, 3, 32'h0,         2'd0, "st_w");
        xact(0, 0, 2'd2, B,     32'h0,         0, 3, 32'hDEAD_BEEF, 2'd0, "ld_w");
        xact(0, 1, 2'd0, B+3,   32'h1234_5680, 0, 3, 32'h0,         2'd0, "st_b");
        xact(0, 0, 2'd0, B+3,   32'h0,         1, 3, 32'hFFFF_FF80, 2'd0, "ld_b_sx");
        xact(0, 0, 2'd0, B+3,   32'h0,         0, 3, 32'h0000_0080, 2'd0, "ld_b_zx");
        xact(0, 0, 2'd2, B,     32'h0,         0, 3, 32'h80AD_BEEF, 2'd0, "ld_w_b");
        xact(0, 0, 2'd0, B+1,   32'h0,         1, 3, 32'hFFFF_FFBE, 2'd0, "ld_b1_sx");
        xact(0, 1, 2'd2, B+4,   32'h1122_3344, 0, 3, 32'h0,         2'd0, "st_w4");
        xact(0, 1, 2'd1, B+6,   32'hABCD_1234, 0, 3, 32'h0,         2'd0, "st_h");
        xact(0, 0, 2'd2, B+4,   32'h0,         0, 3, 32'h1234_3344, 2'd0, "ld_w4");
        xact(0, 0, 2'd1, B+4,   32'h0,         1, 3, 32'h0000_3344, 2'd0, "ld_h_lo");
        xact(0, 1, 2'd1, B+8,   32'h0000_8001, 0, 3, 32'h0,         2'd0, "st_h8");
        xact(0, 0, 2'd1, B+8,   32'h0,         1, 3, 32'hFFFF_8001, 2'd0, "ld_h8_sx");
        xact(0, 1, 2'd2, B+32'hFFC, 32'hA5A5_5A5A, 0, 3, 32'h0,     2'd0, "st_last");
        xact(0, 0, 2'd2, B+32'hFFC, 32'h0,     0, 3, 32'hA5A5_5A5A, 2'd0, "ld_last");

        // Errors: one edge to response, no write
        xact(0, 0, 2'd1, B+1,        32'h0,         1, 1, 32'h0, 2'd1, "e_ld_h_mis");
        xact(0, 1, 2'd2, B+32'h1000, 32'hFFFF_FFFF, 0, 1, 32'h0, 2'd2, "e_st_hi");
        xact(0, 1, 2'd2, B-4,        32'hFFFF_FFFF, 0, 1, 32'h0, 2'd2, "e_st_lo");
        xact(0, 1, 2'd3, B,          32'hFFFF_FFFF, 0, 1, 32'h0, 2'd3, "e_st_ill");
        xact(0, 0, 2'd3, B+1,        32'h0,         0, 1, 32'h0, 2'd3, "e_ill_prio");
        xact(0, 1, 2'd1, B+5,        32'hFFFF_FFFF, 0, 1, 32'h0, 2'd1, "e_st_h_mis");
        xact(0, 1, 2'd2, B+2,        32'hFFFF_FFFF, 0, 1, 32'h0, 2'd1, "e_st_w_mis");
        xact(0, 1, 2'd2, B+32'h1002, 32'hFFFF_FFFF, 0, 1, 32'h0, 2'd1, "e_mis_prio");
        xact(0, 0, 2'd2, B,          32'h0, 0, 3, 32'h80AD_BEEF, 2'd0, "chk_w0");
        xact(0, 0, 2'd2, B+4,        32'h0, 0, 3, 32'h1234_3344, 2'd0, "chk_w4");

        // Backpressure with a second request pending
        @(negedge clk);
        req_wen = 1'b0; req_type = 2'd2; req_addr = B; req_sext = 1'b0;
        rsp_ready = 1'b0; a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("bp.busy", 32'(a_req_ready), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("bp.valid", 32'(a_rsp_valid), 32'd1);
        @(negedge clk);
        req_addr = B + 4; a_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 32'(a_rsp_valid), 32'd1);
            check("bp.hold_rdata", a_rsp_rdata, 32'h80AD_BEEF);
            check("bp.hold_err",   32'(a_rsp_err), 32'd0);
            check("bp.hold_ready", 32'(a_req_ready), 32'd0);
        end
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.hs_valid", 32'(a_rsp_valid), 32'd0);
        check("bp.hs_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("bp.acc2", 32'(a_req_ready), 32'd0);
        repeat (3) @(posedge clk); #1;
        check("bp.r2_valid", 32'(a_rsp_valid), 32'd1);
        check("bp.r2_rdata", a_rsp_rdata, 32'h1234_3344);
        @(posedge clk); #1;
        check("bp.r2_done", 32'(a_req_ready), 32'd1);

        // Instance B: reset during WAIT aborts a store
        xact(1, 1, 2'd2, B, 32'hCAFE_F00D, 0, 6, 32'h0,         2'd0, "b_st");
        xact(1, 0, 2'd2, B, 32'h0,         0, 6, 32'hCAFE_F00D, 2'd0, "b_ld0");
        @(negedge clk);
        req_wen = 1'b1; req_type = 2'd2; req_addr = B; req_wdata = 32'h0BAD_F00D;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        check("b_rst.busy", 32'(b_req_ready), 32'd0);
        @(posedge clk); #2;
        b_rst_n = 1'b0;
        #1;
        check("b_rst.ready", 32'(b_req_ready), 32'd1);
        check("b_rst.valid", 32'(b_rsp_valid), 32'd0);
        check("b_rst.rdata", b_rsp_rdata, 32'd0);
        check("b_rst.err",   32'(b_rsp_err), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); b_rst_n = 1'b1;
        xact(1, 0, 2'd2, B, 32'h0, 0, 6, 32'hCAFE_F00D, 2'd0, "b_ld1");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
